// File: rtl/mux_pkg.sv
// Shared definitions for the 8-channel round-robin mux and its demux partner.
package mux_pkg;

    localparam int NCH  = 8;
    localparam int SELW = 3;

    // Channel index, in the encoding the demux side uses for its select.
    typedef logic [SELW-1:0] sel_t;

    // Output register occupancy.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter8.sv
// Rotating-priority arbiter: grants the first requester at or above ptr,
// wrapping modulo 8. Purely combinational.
module rr_arbiter8
    import mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  sel_t           ptr,
    output logic [NCH-1:0] grant,
    output sel_t           gidx
);

    logic found;
    sel_t idx;

    // Scan from ptr upward, first set request wins; all-zero grant when idle.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = ptr + sel_t'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux8.sv
// Merges 8 valid/ready channels onto one registered stream, tagging each
// word with its source channel. One-entry output register, full throughput
// via same-cycle drain and refill.
module rr_mux8 #(
    parameter int W   = 8,
    parameter int NCH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        a_valid,
    input  logic [NCH-1:0][W-1:0] a_data,
    output logic [NCH-1:0]        a_ready,
    output logic                  y_valid,
    output logic [W-1:0]          y_data,
    output mux_pkg::sel_t         y_sel,
    input  logic                  y_ready
);

    import mux_pkg::*;

    state_t         state_q, state_d;
    sel_t           ptr_q, ptr_d;
    sel_t           y_sel_q, y_sel_d;
    logic [W-1:0]   y_data_q, y_data_d;
    logic [NCH-1:0] grant;
    sel_t           gidx;
    logic           any_valid;
    logic           load_en;
    logic           load;

    assign any_valid = |a_valid;

    rr_arbiter8 u_arb (
        .req   (a_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx)
    );

    // State register: EMPTY/FULL occupancy of the output slot.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next state: fill when a word arrives, empty only when drained with nothing to refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (any_valid)              state_d = ST_FULL;
            ST_FULL:  if (y_ready && !any_valid)  state_d = ST_EMPTY;
            default:                              state_d = ST_EMPTY;
        endcase
    end

    // Outputs and handshake: slot may be loaded when empty or draining this cycle.
    always_comb begin
        y_valid = (state_q == ST_FULL);
        load_en = (state_q == ST_EMPTY) || y_ready;
        a_ready = (load_en && !rst) ? grant : '0;
        load    = load_en && any_valid && !rst;
    end

    // Next-state for the data slot and pointer; held values survive a drain.
    always_comb begin
        y_data_d = y_data_q;
        y_sel_d  = y_sel_q;
        ptr_d    = ptr_q;
        if (load) begin
            y_data_d = a_data[gidx];
            y_sel_d  = gidx;
            ptr_d    = gidx + sel_t'(1);
        end
    end

    // Data slot and priority pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_data_q <= '0;
            y_sel_q  <= '0;
            ptr_q    <= '0;
        end else begin
            y_data_q <= y_data_d;
            y_sel_q  <= y_sel_d;
            ptr_q    <= ptr_d;
        end
    end

    assign y_data = y_data_q;
    assign y_sel  = y_sel_q;

endmodule

// File: tb/tb_rr_mux8.sv
// Directed bench for rr_mux8: table of per-cycle vectors plus a few
// hand-written multi-cycle sequences.
module tb_rr_mux8;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      a_valid;
    logic [7:0][7:0] a_data;
    logic [7:0]      a_ready;
    logic            y_valid;
    logic [7:0]      y_data;
    logic [2:0]      y_sel;
    logic            y_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux8 #(.W(8), .NCH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_sel   (y_sel),
        .y_ready (y_ready)
    );

    // One cycle: inputs applied, a_ready expected before the edge,
    // y_* expected after the edge.
    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] av;
        logic       yr;
        logic [7:0] ar;
        logic       yv;
        logic [2:0] sel;
        logic [7:0] d;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic r, input logic [7:0] av, input logic yr,
                       input logic [7:0] ar, input logic yv, input logic [2:0] sel,
                       input logic [7:0] d);
        vec_t v;
        v.name = nm; v.rst = r; v.av = av; v.yr = yr;
        v.ar = ar; v.yv = yv; v.sel = sel; v.d = d;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_default_data();
        for (int i = 0; i < 8; i++) a_data[i] = 8'h10 + 8'(i);
    endtask

    initial begin
        rst = 1'b1; a_valid = 8'h00; y_ready = 1'b0;
        set_default_data();

        // Reset with all channels requesting.
        add("rst0", 1, 8'hFF, 1, 8'h00, 0, 3'd0, 8'h00);
        add("rst1", 1, 8'hFF, 1, 8'h00, 0, 3'd0, 8'h00);
        // Round robin 0..7 then 0.
        for (int i = 0; i < 9; i++)
            add($sformatf("rr%0d", i), 0, 8'hFF, 1, 8'(1 << (i % 8)), 1, 3'(i % 8), 8'h10 + 8'(i % 8));
        // Fresh reset, then park channel 3 in the slot.
        add("rst2",  1, 8'hFF, 0, 8'h00, 0, 3'd0, 8'h00);
        add("ld3",   0, 8'h08, 1, 8'h08, 1, 3'd3, 8'h13);
        // Backpressure: held for 5 cycles, nothing accepted.
        for (int i = 0; i < 5; i++)
            add($sformatf("bp%0d", i), 0, 8'hFF, 0, 8'h00, 1, 3'd3, 8'h13);
        add("bp_rel", 0, 8'hFF, 1, 8'h10, 1, 3'd4, 8'h14);
        // Drain to empty, then a single word on channel 5.
        add("drain",  0, 8'h00, 1, 8'h00, 0, 3'd4, 8'h14);
        add("ch5",    0, 8'h20, 1, 8'h20, 1, 3'd5, 8'h15);
        add("ch5_e",  0, 8'h00, 1, 8'h00, 0, 3'd5, 8'h15);
        add("ch5_e2", 0, 8'h00, 1, 8'h00, 0, 3'd5, 8'h15);
        // Sparse channels 0 and 2 with ptr at 6: 0, 2, 0.
        add("sp0", 0, 8'h05, 1, 8'h01, 1, 3'd0, 8'h10);
        add("sp1", 0, 8'h05, 1, 8'h04, 1, 3'd2, 8'h12);
        add("sp2", 0, 8'h05, 1, 8'h01, 1, 3'd0, 8'h10);
        // Mid-operation reset coinciding with a drain; restart at channel 0.
        add("hold",   0, 8'hFF, 0, 8'h00, 1, 3'd0, 8'h10);
        add("midrst", 1, 8'hFF, 1, 8'h00, 0, 3'd0, 8'h00);
        add("post0",  0, 8'hFF, 1, 8'h01, 1, 3'd0, 8'h10);

        foreach (vecs[n]) begin
            @(negedge clk);
            rst = vecs[n].rst; a_valid = vecs[n].av; y_ready = vecs[n].yr;
            #1;
            chk({vecs[n].name, ".a_ready"}, 32'(a_ready), 32'(vecs[n].ar));
            @(posedge clk); #1;
            chk({vecs[n].name, ".y_valid"}, 32'(y_valid), 32'(vecs[n].yv));
            chk({vecs[n].name, ".y_sel"},   32'(y_sel),   32'(vecs[n].sel));
            chk({vecs[n].name, ".y_data"},  32'(y_data),  32'(vecs[n].d));
        end

        // Slot held (ch0, ptr=1) while a_data churns: outputs must not move.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            a_valid = 8'hFF; y_ready = 1'b0;
            for (int i = 0; i < 8; i++) a_data[i] = 8'($urandom);
            #1;
            chk("churn.a_ready", 32'(a_ready), 32'h00);
            @(posedge clk); #1;
            chk("churn.y_valid", 32'(y_valid), 32'h1);
            chk("churn.y_data",  32'(y_data),  32'h10);
            chk("churn.y_sel",   32'(y_sel),   32'h0);
        end
        @(negedge clk);
        set_default_data(); y_ready = 1'b1;
        #1;
        chk("resume.a_ready", 32'(a_ready), 32'h02);
        @(posedge clk); #1;
        chk("resume.y_sel",  32'(y_sel),  32'h1);
        chk("resume.y_data", 32'(y_data), 32'h11);

        // Lone channel 7: bounded wait for its word to appear.
        begin
            bit got = 1'b0;
            @(negedge clk);
            a_valid = 8'h80; y_ready = 1'b1;
            for (int c = 0; c < 10 && !got; c++) begin
                @(posedge clk); #1;
                if (y_valid && y_sel == 3'd7) got = 1'b1;
            end
            chk("ch7.seen", 32'(got), 32'h1);
            chk("ch7.y_data", 32'(y_data), 32'h17);
            @(negedge clk);
            a_valid = 8'h00;
            @(posedge clk); #1;
            chk("ch7.empty", 32'(y_valid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
